// File: rtl/blockade_snd_pkg.sv
// -----------------------------------------------------------------------------
// blockade_snd_pkg
// Shared definitions for the Blockade sound responder.
//   SND_PORT_*  : OUT port numbers decoded by blockade_sound (exact match)
//   env_state_t : envelope FSM states used by blockade_snd_env
// No ports (package only).
// -----------------------------------------------------------------------------
package blockade_snd_pkg;

  localparam logic [7:0] SND_PORT_COIN    = 8'h01;
  localparam logic [7:0] SND_PORT_FREQ    = 8'h02;
  localparam logic [7:0] SND_PORT_ENV_ON  = 8'h04;
  localparam logic [7:0] SND_PORT_ENV_OFF = 8'h08;

  typedef enum logic [1:0] {
    ENV_OFF,
    ENV_SUSTAIN,
    ENV_DECAY
  } env_state_t;

endpackage

// File: rtl/blockade_snd_env.sv
// -----------------------------------------------------------------------------
// blockade_snd_env
// Envelope FSM for the Blockade sound responder. Holds the amplitude that the
// top level gates with the square wave.
//
// Configuration macro: BLOCKADE_SND_ENVELOPE_EN
//   defined   : OFF / SUSTAIN / DECAY with a decay prescaler; amp ramps down
//               by one every DECAY_DIV clocks after env_off.
//   undefined : env_off drops amp straight to zero; no DECAY state and no
//               decay prescaler are built, DECAY_DIV is not used.
//
// Parameters:
//   DECAY_DIV : clocks per amplitude decrement step (>= 2)
//   AMP_MAX   : amplitude loaded by env_on
// Ports:
//   clk     in  1 : system clock
//   reset   in  1 : synchronous, active-high
//   env_on  in  1 : single-cycle pulse, start/restart the note
//   env_off in  1 : single-cycle pulse, release the note
//   amp     out 8 : current envelope amplitude
// -----------------------------------------------------------------------------
module blockade_snd_env
  import blockade_snd_pkg::*;
#(
  parameter int         DECAY_DIV = 4096,
  parameter logic [7:0] AMP_MAX   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       env_on,
  input  logic       env_off,
  output logic [7:0] amp
);

  env_state_t state;

`ifdef BLOCKADE_SND_ENVELOPE_EN

  localparam int DW = $clog2(DECAY_DIV);

  logic [DW-1:0] decay_cnt;
  logic          decay_wrap;

  assign decay_wrap = (decay_cnt == DW'(DECAY_DIV - 1));

  // Envelope FSM. env_on wins from any state and restarts the note with a
  // fresh prescaler, so the first decay step after a release always takes a
  // full DECAY_DIV clocks. The prescaler only runs while decaying. The final
  // step (amp of 1 or already 0) lands on zero and leaves DECAY in the same
  // clock, so amp can never wrap below zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ENV_OFF;
      amp       <= 8'h00;
      decay_cnt <= '0;
    end else if (env_on) begin
      state     <= ENV_SUSTAIN;
      amp       <= AMP_MAX;
      decay_cnt <= '0;
    end else begin
      case (state)
        ENV_SUSTAIN: begin
          decay_cnt <= '0;
          if (env_off) begin
            state <= ENV_DECAY;
          end
        end
        ENV_DECAY: begin
          if (decay_wrap) begin
            decay_cnt <= '0;
            if (amp <= 8'd1) begin
              amp   <= 8'h00;
              state <= ENV_OFF;
            end else begin
              amp <= amp - 8'd1;
            end
          end else begin
            decay_cnt <= decay_cnt + DW'(1);
          end
        end
        default: begin
          state     <= ENV_OFF;
          amp       <= 8'h00;
          decay_cnt <= '0;
        end
      endcase
    end
  end

`else

  // Gate-style envelope: env_on opens the note at full amplitude and env_off
  // silences it on the very next clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ENV_OFF;
      amp   <= 8'h00;
    end else if (env_on) begin
      state <= ENV_SUSTAIN;
      amp   <= AMP_MAX;
    end else if (env_off) begin
      state <= ENV_OFF;
      amp   <= 8'h00;
    end
  end

`endif

endmodule

// File: rtl/blockade_sound.sv
// -----------------------------------------------------------------------------
// blockade_sound
// OUT-cycle responder for the Blockade core: detects the rising edge of the
// OUTP strobe, decodes the port number, keeps the coin latch and tone
// frequency, drives the envelope and produces an 8-bit unsigned square-wave
// sample.
//
// Configuration macro: BLOCKADE_SND_ENVELOPE_EN (see blockade_snd_env).
//
// Parameters:
//   TONE_DIV  : clocks per tone base tick (>= 2)
//   DECAY_DIV : clocks per envelope decrement step (>= 2)
//   AMP_MAX   : amplitude loaded on envelope-on
// Ports:
//   clk        in  1 : system clock
//   reset      in  1 : synchronous, active-high
//   outp       in  1 : level OUT strobe, held high several clocks per OUT
//   io_addr    in  8 : port number, stable while outp is high
//   io_data    in  8 : write data, stable while outp is high
//   coin_latch out 1 : coin latch state
//   freq       out 8 : current frequency register
//   audio      out 8 : unsigned mono sample
// -----------------------------------------------------------------------------
module blockade_sound
  import blockade_snd_pkg::*;
#(
  parameter int         TONE_DIV  = 512,
  parameter int         DECAY_DIV = 4096,
  parameter logic [7:0] AMP_MAX   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       outp,
  input  logic [7:0] io_addr,
  input  logic [7:0] io_data,
  output logic       coin_latch,
  output logic [7:0] freq,
  output logic [7:0] audio
);

  localparam int TW = $clog2(TONE_DIV);

  logic          outp_q;
  logic          wr_edge;
  logic          wr_q;
  logic [7:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          env_on;
  logic          env_off;
  logic [TW-1:0] tone_cnt;
  logic          tone_tick;
  logic [7:0]    div_cnt;
  logic          square;
  logic [7:0]    amp;

  assign wr_edge = outp & ~outp_q;

  // Edge detect plus a one-deep write capture. outp_q resets high so a strobe
  // that is already high when reset releases is treated as old and never
  // fires. The captured write is applied on the following clock, which also
  // lets a reset in the edge cycle discard the write cleanly.
  always_ff @(posedge clk) begin
    if (reset) begin
      outp_q  <= 1'b1;
      wr_q    <= 1'b0;
      wr_addr <= 8'h00;
      wr_data <= 8'h00;
    end else begin
      outp_q <= outp;
      wr_q   <= wr_edge;
      if (wr_edge) begin
        wr_addr <= io_addr;
        wr_data <= io_data;
      end
    end
  end

  assign env_on  = wr_q && (wr_addr == SND_PORT_ENV_ON);
  assign env_off = wr_q && (wr_addr == SND_PORT_ENV_OFF);

  // Port registers written by the decoded OUT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      coin_latch <= 1'b0;
      freq       <= 8'h00;
    end else if (wr_q) begin
      if (wr_addr == SND_PORT_COIN) begin
        coin_latch <= wr_data[7];
      end
      if (wr_addr == SND_PORT_FREQ) begin
        freq <= wr_data;
      end
    end
  end

  assign tone_tick = (tone_cnt == TW'(TONE_DIV - 1));

  // Tone generator: div_cnt counts ticks up from the reload value to 8'hFF,
  // then reloads from freq and flips the square wave. freq is only sampled at
  // reload, so a mid-period write never shortens the current half-period.
  always_ff @(posedge clk) begin
    if (reset) begin
      tone_cnt <= '0;
      div_cnt  <= 8'h00;
      square   <= 1'b0;
    end else if (tone_tick) begin
      tone_cnt <= '0;
      if (div_cnt == 8'hFF) begin
        div_cnt <= freq;
        square  <= ~square;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end else begin
      tone_cnt <= tone_cnt + TW'(1);
    end
  end

  blockade_snd_env #(
    .DECAY_DIV (DECAY_DIV),
    .AMP_MAX   (AMP_MAX)
  ) u_env (
    .clk     (clk),
    .reset   (reset),
    .env_on  (env_on),
    .env_off (env_off),
    .amp     (amp)
  );

  // Registered output sample: envelope amplitude while the square is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      audio <= 8'h00;
    end else begin
      audio <= square ? amp : 8'h00;
    end
  end

endmodule

// File: tb/tb_blockade_sound.sv
// -----------------------------------------------------------------------------
// tb_blockade_sound
// Self-checking bench for blockade_sound with TONE_DIV = 4, DECAY_DIV = 4.
// Expectations come from a small behavioural model: port writes update
// m_freq / m_coin, tone half-periods are (256 - freq) * TONE_DIV clocks, and
// the decay amplitude t clocks after release is AMP_MAX - t / DECAY_DIV,
// floored at zero. Envelope expectations follow BLOCKADE_SND_ENVELOPE_EN.
// -----------------------------------------------------------------------------
module tb_blockade_sound;

  localparam int         TONE_DIV  = 4;
  localparam int         DECAY_DIV = 4;
  localparam logic [7:0] AMP_MAX   = 8'hFF;

  logic       clk = 1'b0;
  logic       reset;
  logic       outp;
  logic [7:0] io_addr;
  logic [7:0] io_data;
  logic       coin_latch;
  logic [7:0] freq;
  logic [7:0] audio;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_freq;
  logic       m_coin;

  blockade_sound #(
    .TONE_DIV  (TONE_DIV),
    .DECAY_DIV (DECAY_DIV),
    .AMP_MAX   (AMP_MAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .outp       (outp),
    .io_addr    (io_addr),
    .io_data    (io_data),
    .coin_latch (coin_latch),
    .freq       (freq),
    .audio      (audio)
  );

  always #5 clk = ~clk;

  // Reference rule for a completed OUT cycle.
  function automatic void model_write(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'h01) m_coin = d[7];
    else if (a == 8'h02) m_freq = d;
  endfunction

  // Decay amplitude t clocks after the release edge.
  function automatic logic [7:0] model_decay(input int t);
    int v;
    v = int'(AMP_MAX) - t / DECAY_DIV;
    if (v < 0) v = 0;
    return v[7:0];
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise outp with a new address/data just after a clock edge.
  task automatic start_write(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    outp    = 1'b1;
    io_addr = a;
    io_data = d;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int hold);
    start_write(a, d);
    step(hold);
    outp = 1'b0;
    model_write(a, d);
    step(1);
  endtask

  // Wait for the next change of audio, bounded.
  task automatic wait_change(output int cyc, output bit ok);
    logic [7:0] prev;
    prev = audio;
    cyc  = 0;
    ok   = 1'b0;
    while (cyc < 3000 && !ok) begin
      step(1);
      cyc++;
      if (audio !== prev) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    outp    = 1'b1;
    io_addr = 8'h02;
    io_data = 8'h55;
    m_freq  = 8'h00;
    m_coin  = 1'b0;
    step(3);
    checks++; if (audio !== 8'h00) begin errors++; $display("[TB] FAIL reset_audio got %h want 00", audio); end
    checks++; if (coin_latch !== 1'b0) begin errors++; $display("[TB] FAIL reset_coin got %b want 0", coin_latch); end
    checks++; if (freq !== 8'h00) begin errors++; $display("[TB] FAIL reset_freq got %h want 00", freq); end
    // strobe already high across reset release must not fire
    reset = 1'b0;
    step(4);
    checks++; if (freq !== 8'h00) begin errors++; $display("[TB] FAIL inflight_refire got %h want 00", freq); end
    outp = 1'b0;
    step(2);
    // long 20-clock strobe
    start_write(8'h02, 8'hF0);
    step(1);
    checks++; if (freq !== 8'h00) begin errors++; $display("[TB] FAIL freq_edge1 got %h want 00", freq); end
    step(1);
    checks++; if (freq !== 8'hF0) begin errors++; $display("[TB] FAIL freq_edge2 got %h want f0", freq); end
    step(18);
    outp = 1'b0;
    model_write(8'h02, 8'hF0);
    step(2);
    checks++; if (freq !== m_freq) begin errors++; $display("[TB] FAIL freq_long_hold got %h want %h", freq, m_freq); end
  endtask

  task automatic test_coin_ports;
    logic [7:0] a;
    logic [7:0] d;
    do_write(8'h01, 8'h80, 3);
    checks++; if (coin_latch !== 1'b1) begin errors++; $display("[TB] FAIL coin_set got %b want 1", coin_latch); end
    do_write(8'h01, 8'h7F, 3);
    checks++; if (coin_latch !== 1'b0) begin errors++; $display("[TB] FAIL coin_clear got %b want 0", coin_latch); end
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      do_write(8'h01, d, 2 + int'($urandom_range(0, 5)));
      checks++; if (coin_latch !== m_coin) begin errors++; $display("[TB] FAIL coin_rand d=%h got %b want %b", d, coin_latch, m_coin); end
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 0) a = 8'h03;
      else if (i == 1) a = 8'h10;
      else begin
        a = 8'($urandom);
        if (a == 8'h01 || a == 8'h02 || a == 8'h04 || a == 8'h08) a = 8'hA5;
      end
      d = 8'($urandom) | 8'h80;
      do_write(a, d, 3);
      checks++; if (freq !== m_freq || coin_latch !== m_coin || dut.u_env.amp !== 8'h00) begin
        errors++;
        $display("[TB] FAIL ignored_port a=%h got freq %h coin %b amp %h want freq %h coin %b amp 00",
                 a, freq, coin_latch, dut.u_env.amp, m_freq, m_coin);
      end
    end
  endtask

  task automatic test_tone;
    logic [7:0] flist [4];
    logic [7:0] f;
    logic [7:0] want;
    int cyc;
    bit ok;
    flist[0] = 8'hFF;
    flist[1] = 8'hFE;
    flist[2] = 8'($urandom_range(8'hE0, 8'hFD));
    flist[3] = 8'h00;
    do_write(8'h04, 8'h00, 3);
    for (int i = 0; i < 4; i++) begin
      f = flist[i];
      do_write(8'h02, f, 3);
      wait_change(cyc, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL tone_sync f=%h no toggle within %0d clk", f, cyc); end
      for (int g = 0; g < 2; g++) begin
        want = (audio == 8'h00) ? AMP_MAX : 8'h00;
        wait_change(cyc, ok);
        checks++; if (!ok || cyc != (256 - int'(f)) * TONE_DIV) begin
          errors++;
          $display("[TB] FAIL tone_period f=%h got %0d clk want %0d", f, cyc, (256 - int'(f)) * TONE_DIV);
        end
        checks++; if (audio !== want) begin errors++; $display("[TB] FAIL tone_level f=%h got %h want %h", f, audio, want); end
      end
    end
  endtask

  task automatic test_decay;
    bit bad;
    do_write(8'h04, 8'h00, 3);
    checks++; if (dut.u_env.amp !== AMP_MAX) begin errors++; $display("[TB] FAIL env_on_amp got %h want %h", dut.u_env.amp, AMP_MAX); end
    start_write(8'h08, 8'h00);
    step(1);
    checks++; if (dut.u_env.amp !== AMP_MAX) begin errors++; $display("[TB] FAIL env_off_edge1 got %h want %h", dut.u_env.amp, AMP_MAX); end
    step(1);
    outp = 1'b0;
`ifdef BLOCKADE_SND_ENVELOPE_EN
    bad = 1'b0;
    for (int t = 1; t <= 256 * DECAY_DIV && !bad; t++) begin
      step(1);
      checks++; if (dut.u_env.amp !== model_decay(t)) begin
        errors++; bad = 1'b1;
        $display("[TB] FAIL decay_ramp t=%0d got %h want %h", t, dut.u_env.amp, model_decay(t));
      end
    end
    bad = 1'b0;
    for (int t = 0; t < 40 && !bad; t++) begin
      step(1);
      checks++; if (dut.u_env.amp !== 8'h00) begin errors++; bad = 1'b1; $display("[TB] FAIL decay_wrap got %h want 00", dut.u_env.amp); end
    end
    do_write(8'h08, 8'h00, 3);
    step(10);
    checks++; if (dut.u_env.amp !== 8'h00) begin errors++; $display("[TB] FAIL off_env_off got %h want 00", dut.u_env.amp); end
    // restart from DECAY at amp 8'h40
    do_write(8'h04, 8'h00, 3);
    start_write(8'h08, 8'h00);
    step(2);
    outp = 1'b0;
    step(765);
    start_write(8'h04, 8'h00);
    step(1);
    checks++; if (dut.u_env.amp !== model_decay(767)) begin errors++; $display("[TB] FAIL restart_pre got %h want %h", dut.u_env.amp, model_decay(767)); end
    step(1);
    checks++; if (dut.u_env.amp !== AMP_MAX) begin errors++; $display("[TB] FAIL restart_amp got %h want %h", dut.u_env.amp, AMP_MAX); end
    outp = 1'b0;
    step(2);
`else
    bad = 1'b0;
    checks++; if (dut.u_env.amp !== 8'h00) begin errors++; $display("[TB] FAIL env_off_edge2 got %h want 00", dut.u_env.amp); end
    step(6);
    checks++; if (audio !== 8'h00 || dut.u_env.amp !== 8'h00) begin
      errors++; $display("[TB] FAIL env_off_silent got audio %h amp %h want 00 00", audio, dut.u_env.amp);
    end
    start_write(8'h04, 8'h00);
    step(1);
    checks++; if (dut.u_env.amp !== 8'h00) begin errors++; $display("[TB] FAIL restart_pre got %h want 00", dut.u_env.amp); end
    step(1);
    checks++; if (dut.u_env.amp !== AMP_MAX) begin errors++; $display("[TB] FAIL restart_amp got %h want %h", dut.u_env.amp, AMP_MAX); end
    outp = 1'b0;
    step(2);
`endif
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    d = 8'($urandom) | 8'h01;
    start_write(8'h02, d);
    step(2);
    outp = 1'b0;
    step(1);
    outp    = 1'b1;
    io_addr = 8'h01;
    io_data = 8'h80;
    step(2);
    outp = 1'b0;
    model_write(8'h02, d);
    model_write(8'h01, 8'h80);
    checks++; if (freq !== m_freq || coin_latch !== m_coin) begin
      errors++; $display("[TB] FAIL back_to_back got freq %h coin %b want %h %b", freq, coin_latch, m_freq, m_coin);
    end
    step(2);
  endtask

  task automatic test_reset_race;
    bit bad;
    do_write(8'h01, 8'h80, 3);
    do_write(8'h02, 8'($urandom_range(1, 255)), 3);
    do_write(8'h04, 8'h00, 3);
`ifdef BLOCKADE_SND_ENVELOPE_EN
    do_write(8'h08, 8'h00, 3);
`endif
    step(40);
    @(posedge clk);
    #1 reset = 1'b1;
    step(1);
    reset  = 1'b0;
    m_freq = 8'h00;
    m_coin = 1'b0;
    checks++; if (dut.u_env.amp !== 8'h00 || audio !== 8'h00 || freq !== 8'h00 || coin_latch !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_env got amp %h audio %h freq %h coin %b want all zero",
               dut.u_env.amp, audio, freq, coin_latch);
    end
    bad = 1'b0;
    for (int t = 0; t < 30 && !bad; t++) begin
      step(1);
      checks++; if (dut.u_env.amp !== 8'h00) begin errors++; bad = 1'b1; $display("[TB] FAIL reset_stays_off got %h want 00", dut.u_env.amp); end
    end
    // reset coincident with wr_edge
    @(posedge clk);
    #1;
    reset   = 1'b1;
    outp    = 1'b1;
    io_addr = 8'h02;
    io_data = 8'h5A;
    step(1);
    reset = 1'b0;
    checks++; if (freq !== 8'h00 || audio !== 8'h00 || coin_latch !== 1'b0) begin
      errors++; $display("[TB] FAIL race_reset got freq %h audio %h coin %b want 00 00 0", freq, audio, coin_latch);
    end
    step(4);
    checks++; if (freq !== m_freq) begin errors++; $display("[TB] FAIL race_write_lost got %h want %h", freq, m_freq); end
    outp = 1'b0;
    step(2);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_coin_ports();
    test_tone();
    test_decay();
    test_back_to_back();
    test_reset_race();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blockade_sound.md
# blockade_sound

Responder for the CPU's OUT cycles in the Blockade core. It decodes I/O writes qualified by the OUTP strobe, latches the coin-latch bit and the tone frequency, and runs an envelope FSM. It produces an 8-bit unsigned mono square-wave sample and a coin-latch output. It sits beside the CPU, driven from the same address and data lines and the same status-derived OUTP signal the core already generates.

## Interface
- `TONE_DIV`, default 512: clk cycles per tone base tick; legal range is 2 or greater.
- `DECAY_DIV`, default 4096: clk cycles per envelope decrement step; legal range is 2 or greater.
- `AMP_MAX`, default 8'hFF: amplitude loaded on envelope-on.
- `clk` in 1: system clock. One clock domain only.
- `reset` in 1: synchronous, active-high.
- `outp` in 1: level OUT strobe from the CPU status decode; held high for several clk cycles per OUT cycle.
- `io_addr` in 8: port number (CPU `ADDR[7:0]`); must be stable while `outp` is high.
- `io_data` in 8: CPU write data, latched; must be stable while `outp` is high.
- `coin_latch` out 1: coin latch state.
- `freq` out 8: current frequency register, for debug.
- `audio` out 8: unsigned sample.

## Operation
**Write detect**
- `outp_q` is registered from `outp`.
- `wr_edge = outp & ~outp_q`.
- Exactly one port action per OUT cycle, however long `outp` is held.

**Port decode (exact match on `io_addr`; all other values are ignored)**
- 8'h01: `coin_latch <= io_data[7]`.
- 8'h02: `freq <= io_data`.
- 8'h04: envelope on.
- 8'h08: envelope off.

**Tone**
- A prescaler counts 0 to TONE_DIV-1; a tick is issued on wrap.
- On each tick, 8-bit `div_cnt` increments.
- When `div_cnt == 8'hFF` on a tick: `div_cnt <= freq`, and `square` toggles.
- A new `freq` takes effect only at the next reload, so there are no partial-period glitches.
- `freq = 8'hFF`: toggle every tick.
- `freq = 8'h00`: 256 ticks per half-period.

**Envelope FSM (states OFF, SUSTAIN, DECAY)**
- env_on from any state: go to SUSTAIN, `amp <= AMP_MAX`, decay prescaler cleared.
- env_off in SUSTAIN: go to DECAY.
- env_off in DECAY or OFF: no change.
- In DECAY, each DECAY_DIV wrap decrements `amp` by 1.
- When `amp` reaches 0, go to OFF. There is no underflow; `amp` saturates at 0.
- env_on during DECAY restarts at AMP_MAX.

**Output**
- `audio <= square ? amp : 8'h00`, registered.

**Reset values**
- `coin_latch` = 0, `freq` = 0, `audio` = 0.
- `div_cnt` = 0, `square` = 0, `amp` = 0.
- Both prescalers = 0.
- State = OFF.
- `outp_q` = 1, so a write in flight across reset release is not re-fired.

## Timing
- `wr_edge` is asserted in cycle N+1 when `outp` first goes high at cycle N.
- Registers written by the port decode are visible at N+2.
- An envelope change reaches `audio` at N+3.
- A tone toggle reaches `audio` one clk after the tick.
- If `reset` and `wr_edge` occur in the same cycle, reset wins and the write is lost.
- Reset mid-decay: `amp` = 0 and state = OFF on the next clock.
- Envelope and tone counters run independently; a port write never stalls the CPU, and there is no ready/back-pressure.

## Configuration
- Macro: `BLOCKADE_SND_ENVELOPE_EN`.
- Defined: DECAY state and decay prescaler exist, as described above.
- Undefined: env_off goes directly to OFF with `amp <= 0`, effective at N+2. The DECAY state and its prescaler are not synthesized; `DECAY_DIV` is unused.

## Structure
- Package `blockade_snd_pkg` holds:
  - Port constants `SND_PORT_COIN` = 8'h01, `SND_PORT_FREQ` = 8'h02, `SND_PORT_ENV_ON` = 8'h04, `SND_PORT_ENV_OFF` = 8'h08.
  - Envelope state enum `env_state_t` {ENV_OFF, ENV_SUSTAIN, ENV_DECAY}.
- Sub-module `blockade_snd_env`:
  - Owns the FSM, the decay prescaler and `amp`.
  - Inputs: `env_on` and `env_off` single-cycle pulses.
  - Output: `amp`.
  - This is where the `BLOCKADE_SND_ENVELOPE_EN` conditional lives.
- Top level owns edge detect, decode, coin latch, tone generator and output register.

## Test plan
- **Reset:** after reset, `audio` = 0, `coin_latch` = 0 and `freq` = 0. Then `outp` high for 20 clk with addr 8'h02 and data 8'hF0 -> `freq` = 8'hF0 at edge+2, and exactly one write occurs.
- **Tone period:** TONE_DIV = 4, freq = 8'hFE, env_on -> after the first reload, `square` toggles every 2 ticks (8 clk), and `audio` alternates between 8'hFF and 8'h00.
- **Decay:** DECAY_DIV = 4, macro defined; env_on then env_off -> `amp` steps 8'hFF to 8'h00 over 255×4 clk, state = OFF, and `amp` never wraps. With the macro undefined, `amp` = 0 at edge+2.
- **Coin latch and ignored ports:** addr 8'h01 with data 8'h80 sets `coin_latch` = 1, data 8'h7F clears it. addr 8'h03 and 8'h10 change nothing.
- **Restart:** env_on during DECAY at `amp` = 8'h40 -> `amp` = 8'hFF at edge+2.
- **Reset races:** reset asserted during DECAY, and reset coincident with `wr_edge` -> all outputs at reset values next clock, and the write is discarded.
